// File: rtl/audio_pkg.sv
// Shared audio types and helpers for the record/playback path.
// Holds the sample type, recorder state encoding and magnitude helper.
package audio_pkg;

    typedef shortint sample_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DONE
    } rec_state_t;

    // -32768 has no positive twin in 16 bits, so it saturates to 32767.
    function automatic logic [14:0] sample_mag(input sample_t s);
        if (s == sample_t'(16'h8000))
            return 15'h7fff;
        else if (s[15])
            return 15'(-s);
        else
            return 15'(s);
    endfunction

endpackage

// File: rtl/clip_trigger.sv
// Level trigger: fires when a sample's magnitude reaches the threshold.
// Combinational; shared with the gate/envelope path.
module clip_trigger
    import audio_pkg::*;
(
    input  sample_t     sample,
    input  logic [15:0] level,
    input  logic        trig_en,
    output logic        hit
);

    logic [15:0] mag;

    assign mag = {1'b0, sample_mag(sample)};
    assign hit = !trig_en || (mag >= level);

endmodule

// File: rtl/clip_recorder.sv
// Records a clip of incoming audio samples into a parallel-readable buffer
// for player_module, with optional level trigger and decimation.
module clip_recorder
    import audio_pkg::*;
#(
    parameter int CLIP_LEN = 1024,
    parameter int DECIM    = 1
) (
    input  logic                      mclk,
    input  logic                      rst,
    input  sample_t                   in_sample,
    input  logic                      in_valid,
    input  logic                      arm,
    input  logic                      abort,
    input  logic                      trig_en,
    input  logic [15:0]               trig_level,
    output sample_t                   data_buffer [CLIP_LEN],
    output logic [$clog2(CLIP_LEN):0] wr_count,
    output logic                      busy,
    output logic                      done
);

    localparam int CW = $clog2(CLIP_LEN) + 1;
    localparam int AW = $clog2(CLIP_LEN);
    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

    rec_state_t    state_q, state_d;
    logic [CW-1:0] wr_count_q;
    logic [DW-1:0] dcnt_q;
    sample_t       mem_q [CLIP_LEN];

    logic hit;
    logic kept;
    logic wr_en;
    logic clr;
    logic last;

    clip_trigger u_trig (
        .sample  (in_sample),
        .level   (trig_level),
        .trig_en (trig_en),
        .hit     (hit)
    );

    assign kept = in_valid && busy && (dcnt_q == '0);
    assign last = (wr_count_q == CW'(CLIP_LEN - 1));

    always_ff @(posedge mclk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (arm) state_d = ARMED;
                ARMED:   if (kept && hit) state_d = CAPTURE;
                CAPTURE: if (kept && last) state_d = DONE;
                DONE:    if (arm) state_d = ARMED;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy  = (state_q == ARMED) || (state_q == CAPTURE);
        done  = (state_q == DONE);
        wr_en = !abort && kept &&
                (((state_q == ARMED) && hit) || (state_q == CAPTURE));
        clr   = !abort && arm &&
                ((state_q == IDLE) || (state_q == DONE));
    end

    // Decimation phase restarts with every new arming.
    always_ff @(posedge mclk) begin
        if (rst || clr)
            dcnt_q <= '0;
        else if (in_valid && busy && !abort)
            dcnt_q <= (dcnt_q == DW'(DECIM - 1)) ? '0 : dcnt_q + 1'b1;
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            wr_count_q <= '0;
            for (int i = 0; i < CLIP_LEN; i++)
                mem_q[i] <= '0;
        end else if (clr) begin
            wr_count_q <= '0;
        end else if (wr_en) begin
            mem_q[wr_count_q[AW-1:0]] <= in_sample;
            wr_count_q                <= wr_count_q + 1'b1;
        end
    end

    assign data_buffer = mem_q;
    assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_clip_recorder.sv
// Directed scoreboard bench for clip_recorder.
// Two instances (DECIM=1 and DECIM=3) share one stimulus stream.
module tb_clip_recorder;

    logic        mclk;
    logic        rst;
    shortint     in_sample;
    logic        in_valid;
    logic        arm;
    logic        abort;
    logic        trig_en;
    logic [15:0] trig_level;

    shortint     db1 [8];
    shortint     db3 [8];
    logic [3:0]  wc1, wc3;
    logic        busy1, busy3, done1, done3;

    int checks = 0;
    int errors = 0;
    shortint expq [$];

    clip_recorder #(.CLIP_LEN(8), .DECIM(1)) u1 (
        .mclk(mclk), .rst(rst), .in_sample(in_sample),
        .in_valid(in_valid), .arm(arm), .abort(abort),
        .trig_en(trig_en), .trig_level(trig_level),
        .data_buffer(db1), .wr_count(wc1), .busy(busy1), .done(done1)
    );

    clip_recorder #(.CLIP_LEN(8), .DECIM(3)) u3 (
        .mclk(mclk), .rst(rst), .in_sample(in_sample),
        .in_valid(in_valid), .arm(arm), .abort(abort),
        .trig_en(trig_en), .trig_level(trig_level),
        .data_buffer(db3), .wr_count(wc3), .busy(busy3), .done(done3)
    );

    initial mclk = 0;
    always #5 mclk = ~mclk;

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic strobe(input shortint v);
        in_sample = v;
        in_valid  = 1;
        tick();
        in_valid  = 0;
    endtask

    task automatic do_arm();
        arm = 1;
        tick();
        arm = 0;
    endtask

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1; in_sample = 0; in_valid = 0; arm = 0; abort = 0;
        trig_en = 0; trig_level = 0;
        tick(); tick();
        rst = 0;

        chk("rst_wc", 32'(wc1), 0);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_done", 32'(done1), 0);
        chk("rst_buf0", 32'(db1[0]), 0);
        chk("rst_buf7", 32'(db1[7]), 0);

        // decimation by 3
        do_arm();
        chk("dec_busy", 32'(busy3), 1);
        for (int v = 0; v < 24; v++) begin
            if (v % 3 == 0) expq.push_back(shortint'(v));
            strobe(shortint'(v));
        end
        chk("dec_done", 32'(done3), 1);
        chk("dec_wc", 32'(wc3), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("dec_buf%0d", i), 32'(db3[i]), 32'(expq.pop_front()));

        rst = 1; tick(); rst = 0;
        chk("rst2_buf3", 32'(db1[3]), 0);
        chk("rst2_wc3", 32'(wc3), 0);

        // immediate capture
        do_arm();
        chk("imm_busy", 32'(busy1), 1);
        for (int v = 1; v <= 10; v++) begin
            if (v <= 8) expq.push_back(shortint'(v));
            strobe(shortint'(v));
        end
        chk("imm_done", 32'(done1), 1);
        chk("imm_busy_lo", 32'(busy1), 0);
        chk("imm_wc", 32'(wc1), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("imm_buf%0d", i), 32'(db1[i]), 32'(expq.pop_front()));

        // rearm from DONE with level trigger
        trig_en = 1; trig_level = 100;
        do_arm();
        chk("rearm_wc", 32'(wc1), 0);
        chk("rearm_done", 32'(done1), 0);
        chk("rearm_busy", 32'(busy1), 1);
        chk("rearm_keep0", 32'(db1[0]), 1);
        strobe(5);
        strobe(-50);
        chk("trig_wait_wc", 32'(wc1), 0);
        chk("trig_wait_buf", 32'(db1[0]), 1);
        expq.push_back(-120);
        expq.push_back(7);
        strobe(-120);
        strobe(7);
        chk("trig_wc", 32'(wc1), 2);
        chk("trig_busy", 32'(busy1), 1);
        for (int i = 0; i < 2; i++)
            chk($sformatf("trig_buf%0d", i), 32'(db1[i]), 32'(expq.pop_front()));
        chk("trig_keep2", 32'(db1[2]), 3);

        // abort wins over a simultaneous write
        strobe(9);
        chk("pre_abort_wc", 32'(wc1), 3);
        abort = 1;
        strobe(99);
        abort = 0;
        chk("abort_busy", 32'(busy1), 0);
        chk("abort_done", 32'(done1), 0);
        chk("abort_wc", 32'(wc1), 3);
        chk("abort_buf3", 32'(db1[3]), 4);
        strobe(55);
        chk("idle_wc", 32'(wc1), 3);
        chk("idle_buf3", 32'(db1[3]), 4);

        // extreme trigger levels
        trig_level = 16'd32767;
        do_arm();
        chk("edge_arm_wc", 32'(wc1), 0);
        strobe(32766);
        chk("edge_miss_wc", 32'(wc1), 0);
        strobe(-32768);
        chk("edge_hit_wc", 32'(wc1), 1);
        chk("edge_hit_buf", 32'(db1[0]), -32768);
        do_arm();
        chk("arm_busy_ign", 32'(wc1), 1);
        abort = 1; tick(); abort = 0;

        trig_level = 0;
        do_arm();
        strobe(0);
        chk("lvl0_wc", 32'(wc1), 1);
        chk("lvl0_buf", 32'(db1[0]), 0);
        strobe(11);
        strobe(12);
        chk("lvl0_wc3", 32'(wc1), 3);
        chk("lvl0_buf2", 32'(db1[2]), 12);

        // reset mid-capture
        rst = 1; tick(); rst = 0;
        chk("rstm_wc", 32'(wc1), 0);
        chk("rstm_busy", 32'(busy1), 0);
        chk("rstm_done", 32'(done1), 0);
        chk("rstm_buf1", 32'(db1[1]), 0);
        chk("rstm_buf2", 32'(db1[2]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
